// File: rtl/reorder_buffer_mc.sv
// reorder_buffer_mc
//   Multi-commit reorder buffer. One instruction is allocated per cycle at
//   the tail, results arrive on WB_PORTS writeback channels, and up to
//   COMMIT_W completed entries retire per cycle, in order, from the head.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global enable; low freezes all state and outputs
//   issue_*               allocation request (kind, rd, pc, imm, prediction)
//   wb_valid/idx/val      flattened writeback channels, highest port wins
//   mem_busy              memory unit cannot take a store release
//   full/empty/count      occupancy (derived from the registered count)
//   head_idx/tail_idx     oldest entry / next allocation slot
//   cm_valid/rd/val/idx   per-slot registered commit bus
//   st_release            store at head may write memory
//   br_upd/taken/correct/pc  branch-predictor update
//   flush/flush_pc        pipeline redirect
//
// Optional build macro
//   ROB_STATS_EN adds stat_commits / stat_flushes free-running counters.

module reorder_buffer_mc #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         issue_valid,
  input  logic [2:0]                   issue_kind,
  input  logic [4:0]                   issue_rd,
  input  logic [31:0]                  issue_pc,
  input  logic [31:0]                  issue_imm,
  input  logic                         issue_pred,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*32-1:0]       wb_val,
  input  logic                         mem_busy,
  output logic                         full,
  output logic                         empty,
  output logic [IDX_W:0]               count,
  output logic [IDX_W-1:0]             head_idx,
  output logic [IDX_W-1:0]             tail_idx,
  output logic [COMMIT_W-1:0]          cm_valid,
  output logic [COMMIT_W*5-1:0]        cm_rd,
  output logic [COMMIT_W*32-1:0]       cm_val,
  output logic [COMMIT_W*IDX_W-1:0]    cm_idx,
  output logic                         st_release,
  output logic                         br_upd,
  output logic                         br_taken,
  output logic                         br_correct,
  output logic [31:0]                  br_pc,
  output logic                         flush,
  output logic [31:0]                  flush_pc
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]                  stat_commits,
  output logic [31:0]                  stat_flushes
`endif
);

  localparam logic [2:0]     K_STORE = 3'd2;
  localparam logic [2:0]     K_BR    = 3'd3;
  localparam logic [2:0]     K_JALR  = 3'd4;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  // Entry control state (reset) and payload (not reset).
  logic              ent_vld  [DEPTH];
  logic              ent_rdy  [DEPTH];
  logic [2:0]        ent_kind [DEPTH];
  logic [4:0]        ent_rd   [DEPTH];
  logic [31:0]       ent_pc   [DEPTH];
  logic [31:0]       ent_imm  [DEPTH];
  logic              ent_pred [DEPTH];
  logic signed [31:0] ent_res [DEPTH];

  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [IDX_W:0]    count_q;

  assign head_idx = head_q;
  assign tail_idx = tail_q;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);

  logic do_issue;
  logic clear_all;

  // Full is taken from the registered count, so an issue in the same cycle
  // as a retirement from a full buffer is still dropped.
  assign do_issue  = issue_valid && !full;
  assign clear_all = rst_in || (rdy_in && flush);

  // ---- stage p0: commit decision on registered entry state ----
  logic [COMMIT_W-1:0]       ret_mask_p0;
  logic [IDX_W:0]            ret_n_p0;
  logic [COMMIT_W-1:0]       cmv_p0;
  logic [COMMIT_W*5-1:0]     cmrd_p0;
  logic [COMMIT_W*32-1:0]    cmval_p0;
  logic [COMMIT_W*IDX_W-1:0] cmidx_p0;
  logic                      st_p0;
  logic                      brupd_p0;
  logic                      brtaken_p0;
  logic                      brcorr_p0;
  logic [31:0]               brpc_p0;
  logic                      flush_p0;
  logic [31:0]               flushpc_p0;

  always_comb begin
    logic [IDX_W-1:0] sidx;
    logic             go;
    logic             stop;
    ret_mask_p0 = '0;
    ret_n_p0    = '0;
    cmv_p0      = '0;
    cmrd_p0     = '0;
    cmval_p0    = '0;
    cmidx_p0    = '0;
    st_p0       = 1'b0;
    brupd_p0    = 1'b0;
    brtaken_p0  = 1'b0;
    brcorr_p0   = 1'b0;
    brpc_p0     = '0;
    flush_p0    = 1'b0;
    flushpc_p0  = '0;
    stop        = 1'b0;
    sidx        = '0;
    go          = 1'b0;
    for (int s = 0; s < COMMIT_W; s++) begin
      sidx = head_q + IDX_W'(s);
      go   = !stop && ent_vld[sidx] && ent_rdy[sidx];
      // Stores release only from the oldest slot and only when memory is free.
      if (ent_kind[sidx] == K_STORE && (s != 0 || mem_busy))
        go = 1'b0;
      if (!go) begin
        stop = 1'b1;
      end else begin
        ret_mask_p0[s]               = 1'b1;
        ret_n_p0                     = ret_n_p0 + (IDX_W+1)'(1);
        cmv_p0[s]                    = 1'b1;
        cmidx_p0[s*IDX_W +: IDX_W]   = sidx;
        cmval_p0[s*32 +: 32]         = ent_res[sidx];
        case (ent_kind[sidx])
          K_STORE: st_p0 = 1'b1;
          K_BR: begin
            stop       = 1'b1;
            brupd_p0   = 1'b1;
            brtaken_p0 = ent_res[sidx][0];
            brcorr_p0  = (ent_pred[sidx] == ent_res[sidx][0]);
            brpc_p0    = ent_pc[sidx];
            if (ent_pred[sidx] != ent_res[sidx][0]) begin
              flush_p0   = 1'b1;
              flushpc_p0 = ent_res[sidx][0] ? ent_pc[sidx] + ent_imm[sidx]
                                            : ent_pc[sidx] + 32'd4;
            end
          end
          K_JALR: begin
            stop                 = 1'b1;
            cmrd_p0[s*5 +: 5]    = ent_rd[sidx];
            cmval_p0[s*32 +: 32] = ent_pc[sidx] + 32'd4;
            flush_p0             = 1'b1;
            flushpc_p0           = {ent_res[sidx][31:1], 1'b0};
          end
          default: cmrd_p0[s*5 +: 5] = ent_rd[sidx];
        endcase
      end
    end
  end

  // ---- stage p1: registered state and commit outputs ----
  always_ff @(posedge clk_in) begin
    if (clear_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_vld[i] <= 1'b0;
        ent_rdy[i] <= 1'b0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cm_valid   <= '0;
      cm_rd      <= '0;
      cm_val     <= '0;
      cm_idx     <= '0;
      st_release <= 1'b0;
      br_upd     <= 1'b0;
      br_taken   <= 1'b0;
      br_correct <= 1'b0;
      br_pc      <= '0;
      flush      <= 1'b0;
      flush_pc   <= '0;
    end else if (rdy_in) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && ent_vld[wb_idx[k*IDX_W +: IDX_W]])
          ent_rdy[wb_idx[k*IDX_W +: IDX_W]] <= 1'b1;
      end
      for (int s = 0; s < COMMIT_W; s++) begin
        if (ret_mask_p0[s])
          ent_vld[cmidx_p0[s*IDX_W +: IDX_W]] <= 1'b0;
      end
      if (do_issue) begin
        ent_vld[tail_q] <= 1'b1;
        ent_rdy[tail_q] <= 1'b0;
        tail_q          <= tail_q + IDX_W'(1);
      end
      head_q     <= head_q + ret_n_p0[IDX_W-1:0];
      count_q    <= count_q + (IDX_W+1)'(do_issue) - ret_n_p0;
      cm_valid   <= cmv_p0;
      cm_rd      <= cmrd_p0;
      cm_val     <= cmval_p0;
      cm_idx     <= cmidx_p0;
      st_release <= st_p0;
      br_upd     <= brupd_p0;
      br_taken   <= brtaken_p0;
      br_correct <= brcorr_p0;
      br_pc      <= brpc_p0;
      flush      <= flush_p0;
      flush_pc   <= flushpc_p0;
    end
  end

  // Payload storage; qualified by the same conditions as the control path.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in && !flush) begin
      if (do_issue) begin
        ent_kind[tail_q] <= issue_kind;
        ent_rd[tail_q]   <= issue_rd;
        ent_pc[tail_q]   <= issue_pc;
        ent_imm[tail_q]  <= issue_imm;
        ent_pred[tail_q] <= issue_pred;
      end
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && ent_vld[wb_idx[k*IDX_W +: IDX_W]])
          ent_res[wb_idx[k*IDX_W +: IDX_W]] <= wb_val[k*32 +: 32];
      end
    end
  end

`ifdef ROB_STATS_EN
  // Statistics survive pipeline flushes; only reset clears them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_commits <= '0;
      stat_flushes <= '0;
    end else if (rdy_in && !flush) begin
      stat_commits <= stat_commits + 32'(ret_n_p0);
      if (flush_p0)
        stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer_mc.sv
module tb_reorder_buffer_mc;
  localparam int DEPTH = 16, IDX_W = 4, WB_PORTS = 2, COMMIT_W = 2;
  localparam logic [2:0] K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JALR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, issue_valid, issue_pred, mem_busy;
  logic [2:0] issue_kind;
  logic [4:0] issue_rd;
  logic [31:0] issue_pc, issue_imm;
  logic [WB_PORTS-1:0] wb_valid;
  logic [WB_PORTS*IDX_W-1:0] wb_idx;
  logic [WB_PORTS*32-1:0] wb_val;
  logic full, empty, st_release, br_upd, br_taken, br_correct, flush;
  logic [IDX_W:0] count;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic [COMMIT_W-1:0] cm_valid;
  logic [COMMIT_W*5-1:0] cm_rd;
  logic [COMMIT_W*32-1:0] cm_val;
  logic [COMMIT_W*IDX_W-1:0] cm_idx;
  logic [31:0] br_pc, flush_pc;

  reorder_buffer_mc #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_pred(issue_pred),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val), .mem_busy(mem_busy),
    .full(full), .empty(empty), .count(count), .head_idx(head_idx), .tail_idx(tail_idx),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_idx(cm_idx),
    .st_release(st_release), .br_upd(br_upd), .br_taken(br_taken),
    .br_correct(br_correct), .br_pc(br_pc), .flush(flush), .flush_pc(flush_pc));

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        done;
    logic [31:0] res;
  } ent_t;

  ent_t q[$];
  int   m_head;
  logic [1:0]  e_cmv, e_valchk;
  logic [4:0]  e_rd [2];
  logic [31:0] e_val [2];
  logic [3:0]  e_idx [2];
  logic        e_st, e_brupd, e_brtaken, e_brcorr, e_flush;
  logic [31:0] e_brpc, e_flushpc;
  int vectors = 0, errors = 0;

  task automatic clear_exp();
    e_cmv = '0; e_valchk = '0; e_st = 0; e_brupd = 0; e_brtaken = 0; e_brcorr = 0;
    e_flush = 0; e_brpc = '0; e_flushpc = '0;
    for (int s = 0; s < 2; s++) begin e_rd[s] = '0; e_val[s] = '0; e_idx[s] = '0; end
  endtask

  task automatic model_step();
    int presize, nret, p;
    bit stop;
    ent_t e;
    if (rst) begin
      q.delete(); m_head = 0; clear_exp();
    end else if (!rdy) begin
      // everything holds
    end else if (e_flush) begin
      q.delete(); m_head = 0; clear_exp();
    end else begin
      presize = q.size();
      clear_exp();
      nret = 0; stop = 0;
      for (int s = 0; s < COMMIT_W; s++) begin
        if (stop || s >= presize) break;
        e = q[s];
        if (!e.done) break;
        if (e.kind == K_STORE && (s > 0 || mem_busy)) break;
        e_cmv[s] = 1'b1;
        e_idx[s] = 4'((m_head + s) % DEPTH);
        nret++;
        case (e.kind)
          K_STORE: e_st = 1'b1;
          K_BR: begin
            e_brupd = 1'b1; e_brtaken = e.res[0]; e_brcorr = (e.pred == e.res[0]);
            e_brpc = e.pc;
            if (e.pred != e.res[0]) begin
              e_flush = 1'b1;
              e_flushpc = e.res[0] ? e.pc + e.imm : e.pc + 4;
            end
            stop = 1;
          end
          K_JALR: begin
            e_rd[s] = e.rd; e_val[s] = e.pc + 4; e_valchk[s] = 1'b1;
            e_flush = 1'b1; e_flushpc = e.res & ~32'd1;
            stop = 1;
          end
          default: begin e_rd[s] = e.rd; e_val[s] = e.res; e_valchk[s] = 1'b1; end
        endcase
      end
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k]) begin
          p = (int'(wb_idx[k*IDX_W +: IDX_W]) - m_head + DEPTH) % DEPTH;
          if (p < presize) begin
            e = q[p]; e.done = 1'b1; e.res = wb_val[k*32 +: 32]; q[p] = e;
          end
        end
      end
      for (int i = 0; i < nret; i++) void'(q.pop_front());
      m_head = (m_head + nret) % DEPTH;
      if (issue_valid && presize < DEPTH) begin
        e.kind = issue_kind; e.rd = issue_rd; e.pc = issue_pc; e.imm = issue_imm;
        e.pred = issue_pred; e.done = 1'b0; e.res = '0;
        q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_kind = '0; issue_rd = '0; issue_pc = '0; issue_imm = '0;
    issue_pred = 0; wb_valid = '0; wb_idx = '0; wb_val = '0;
  endtask

  task automatic apply_reset();
    idle_inputs(); mem_busy = 0; rdy = 1; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [2:0] k, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    issue_valid = 1; issue_kind = k; issue_rd = rd; issue_pc = pc; issue_imm = imm; issue_pred = pred;
    tick();
    issue_valid = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || head_idx !== 4'd0 || tail_idx !== 4'd0 ||
        cm_valid !== 2'b00 || flush !== 1'b0 || st_release !== 1'b0 || br_upd !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b full=%b head=%0d tail=%0d cmv=%b flush=%b st=%b br=%b, required all zero with empty=1",
               count, empty, full, head_idx, tail_idx, cm_valid, flush, st_release, br_upd);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) issue(K_ALU, 5'(i), 32'(i * 4), 0, 0);
    vectors++;
    if (full !== 1'b1 || count !== 5'd16 || count !== 5'(q.size())) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d, required full=1 count=16", full, count);
    end
    issue(K_ALU, 5'd17, 32'h44, 0, 0);
    vectors++;
    if (count !== 5'd16 || tail_idx !== 4'd0 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_drop: count=%0d tail=%0d full=%b, required 16 0 1", count, tail_idx, full);
    end
  endtask

  task automatic test_dual_commit();
    wb_valid = 2'b01; wb_idx = {4'd0, 4'd1}; wb_val = {32'd0, 32'hA}; tick();
    wb_valid = 2'b01; wb_idx = {4'd0, 4'd0}; wb_val = {32'd0, 32'hB}; tick();
    idle_inputs(); tick();
    vectors++;
    if (cm_valid !== 2'b11 || cm_rd !== {5'd2, 5'd1} || cm_val !== {32'hA, 32'hB} ||
        head_idx !== 4'd2 || count !== 5'd14) begin
      errors++;
      $display("FAIL dual_commit: cmv=%b rd=%h val=%h head=%0d count=%0d, required 11 %h %h 2 14",
               cm_valid, cm_rd, cm_val, head_idx, count, {5'd2, 5'd1}, {32'hA, 32'hB});
    end
  endtask

  task automatic test_store();
    apply_reset();
    mem_busy = 1;
    issue(K_STORE, 5'd7, 32'h200, 0, 0);
    wb_valid = 2'b01; wb_idx = '0; wb_val = {32'd0, 32'h99}; tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (cm_valid !== 2'b00 || st_release !== 1'b0 || count !== 5'd1) begin
        errors++;
        $display("FAIL store_busy: cyc %0d cmv=%b st=%b count=%0d, required 00 0 1", i, cm_valid, st_release, count);
      end
    end
    mem_busy = 0; tick();
    vectors++;
    if (st_release !== 1'b1 || cm_valid !== 2'b01 || cm_rd[4:0] !== 5'd0 || count !== 5'd0) begin
      errors++;
      $display("FAIL store_release: st=%b cmv=%b rd=%0d count=%0d, required 1 01 0 0", st_release, cm_valid, cm_rd[4:0], count);
    end
    tick();
    vectors++;
    if (st_release !== 1'b0 || cm_valid !== 2'b00) begin
      errors++;
      $display("FAIL store_once: st=%b cmv=%b, required 0 00", st_release, cm_valid);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    issue(K_BR, 5'd0, 32'h100, 32'h20, 1'b0);
    issue(K_ALU, 5'd3, 32'h104, 0, 0);
    wb_valid = 2'b11; wb_idx = {4'd1, 4'd0}; wb_val = {32'h55, 32'h1}; tick();
    idle_inputs(); tick();
    vectors++;
    if (cm_valid !== 2'b01 || br_upd !== 1'b1 || br_taken !== 1'b1 || br_correct !== 1'b0 ||
        br_pc !== 32'h100 || flush !== 1'b1 || flush_pc !== 32'h120 || count !== 5'd1) begin
      errors++;
      $display("FAIL branch: cmv=%b upd=%b tk=%b ok=%b pc=%h flush=%b fpc=%h count=%0d, required 01 1 1 0 100 1 120 1",
               cm_valid, br_upd, br_taken, br_correct, br_pc, flush, flush_pc, count);
    end
    tick();
    vectors++;
    if (count !== 5'd0 || flush !== 1'b0 || cm_valid !== 2'b00 || head_idx !== 4'd0 || tail_idx !== 4'd0) begin
      errors++;
      $display("FAIL branch_flush: count=%0d flush=%b cmv=%b head=%0d tail=%0d, required all 0", count, flush, cm_valid, head_idx, tail_idx);
    end
  endtask

  task automatic test_jalr();
    apply_reset();
    issue(K_JALR, 5'd1, 32'h40, 0, 0);
    wb_valid = 2'b01; wb_idx = '0; wb_val = {32'd0, 32'h81}; tick();
    idle_inputs(); tick();
    vectors++;
    if (cm_valid !== 2'b01 || cm_rd[4:0] !== 5'd1 || cm_val[31:0] !== 32'h44 ||
        flush !== 1'b1 || flush_pc !== 32'h80) begin
      errors++;
      $display("FAIL jalr: cmv=%b rd=%0d val=%h flush=%b fpc=%h, required 01 1 44 1 80",
               cm_valid, cm_rd[4:0], cm_val[31:0], flush, flush_pc);
    end
  endtask

  task automatic test_conflict_stall();
    apply_reset();
    for (int i = 1; i <= 4; i++) issue(K_ALU, 5'(i), 32'(i * 4), 0, 0);
    wb_valid = 2'b11; wb_idx = {4'd1, 4'd0}; wb_val = {32'h22, 32'h11}; tick();
    idle_inputs(); tick();
    rdy = 0;
    issue_valid = 1; issue_kind = K_ALU; issue_rd = 5'd9;
    wb_valid = 2'b11; wb_idx = {4'd3, 4'd2}; wb_val = {32'hEE, 32'hDD};
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (count !== 5'd2 || head_idx !== 4'd2 || tail_idx !== 4'd4 || cm_valid !== 2'b11 ||
          cm_val !== {32'h22, 32'h11}) begin
        errors++;
        $display("FAIL stall: cyc %0d count=%0d head=%0d tail=%0d cmv=%b val=%h, required 2 2 4 11 %h",
                 i, count, head_idx, tail_idx, cm_valid, cm_val, {32'h22, 32'h11});
      end
    end
    rdy = 1; idle_inputs();
    wb_valid = 2'b11; wb_idx = {4'd3, 4'd3}; wb_val = {32'h7, 32'h5}; tick();
    vectors++;
    if (cm_valid !== 2'b00 || count !== 5'd2) begin
      errors++;
      $display("FAIL stall_wb_dropped: cmv=%b count=%0d, required 00 2", cm_valid, count);
    end
    wb_valid = 2'b01; wb_idx = {4'd0, 4'd2}; wb_val = {32'd0, 32'h33}; tick();
    idle_inputs(); tick();
    vectors++;
    if (cm_valid !== 2'b11 || cm_val !== {32'h7, 32'h33} || cm_idx !== {4'd3, 4'd2} || count !== 5'd0) begin
      errors++;
      $display("FAIL wb_conflict: cmv=%b val=%h idx=%h count=%0d, required 11 %h 32 0",
               cm_valid, cm_val, cm_idx, count, {32'h7, 32'h33});
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      mem_busy = ($urandom_range(0, 9) < 3);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_kind = 3'($urandom_range(0, 4));
      issue_rd = 5'($urandom);
      issue_pc = $urandom & 32'hFFFF_FFFC;
      issue_imm = $urandom & 32'h0000_0FFC;
      issue_pred = 1'($urandom);
      for (int k = 0; k < WB_PORTS; k++) begin
        wb_valid[k] = ($urandom_range(0, 1) == 1);
        wb_idx[k*IDX_W +: IDX_W] = 4'((m_head + $urandom_range(0, 5)) % DEPTH);
        wb_val[k*32 +: 32] = $urandom;
      end
      tick();
      vectors++;
      if (count !== 5'(q.size()) || head_idx !== 4'(m_head) || tail_idx !== 4'((m_head + q.size()) % DEPTH) ||
          full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        errors++;
        $display("FAIL rand_ptrs: cyc %0d count=%0d head=%0d tail=%0d full=%b empty=%b, required count=%0d head=%0d",
                 cyc, count, head_idx, tail_idx, full, empty, q.size(), m_head);
      end
      vectors++;
      if (cm_valid !== e_cmv || st_release !== e_st || br_upd !== e_brupd || flush !== e_flush) begin
        errors++;
        $display("FAIL rand_pulses: cyc %0d cmv=%b st=%b br=%b flush=%b, required %b %b %b %b",
                 cyc, cm_valid, st_release, br_upd, flush, e_cmv, e_st, e_brupd, e_flush);
      end
      for (int s = 0; s < COMMIT_W; s++) begin
        if (e_cmv[s]) begin
          vectors++;
          if (cm_rd[s*5 +: 5] !== e_rd[s] || cm_idx[s*IDX_W +: IDX_W] !== e_idx[s] ||
              (e_valchk[s] && cm_val[s*32 +: 32] !== e_val[s])) begin
            errors++;
            $display("FAIL rand_slot%0d: cyc %0d rd=%0d idx=%0d val=%h, required %0d %0d %h",
                     s, cyc, cm_rd[s*5 +: 5], cm_idx[s*IDX_W +: IDX_W], cm_val[s*32 +: 32], e_rd[s], e_idx[s], e_val[s]);
          end
        end
      end
      if (e_brupd) begin
        vectors++;
        if (br_taken !== e_brtaken || br_correct !== e_brcorr || br_pc !== e_brpc) begin
          errors++;
          $display("FAIL rand_branch: cyc %0d tk=%b ok=%b pc=%h, required %b %b %h",
                   cyc, br_taken, br_correct, br_pc, e_brtaken, e_brcorr, e_brpc);
        end
      end
      if (e_flush) begin
        vectors++;
        if (flush_pc !== e_flushpc) begin
          errors++;
          $display("FAIL rand_flush_pc: cyc %0d fpc=%h, required %h", cyc, flush_pc, e_flushpc);
        end
      end
    end
    rst = 0; rdy = 1; idle_inputs();
  endtask

  initial begin
    q.delete(); m_head = 0; clear_exp();
    rst = 1; rdy = 1; mem_busy = 0; idle_inputs();
    test_reset();
    test_fill();
    test_dual_commit();
    test_store();
    test_branch();
    test_jalr();
    test_conflict_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
